// File: rtl/fault_counters.sv
// ----------------------------------------------------------------------------
// fault_counters
//
// Error-counter unit of the CAN controller's fault-confinement path.
// Keeps the transmit error counter (TEC), the receive error counter (REC) and
// the bus-off recovery counter (ERB). It decodes the threshold flags that the
// fault-state machine consumes, and takes that machine's resetcount/busoff
// outputs back.
//
// Ports
//   clock          rising-edge system clock
//   reset          asynchronous active-low reset
//   resetcount     active-low synchronous clear of TEC/REC/ERB/run counter
//   busoff         fault-state machine is in bus-off; enables ERB counting
//   tec_inc8       transmit error,        TEC += 8 (saturates at BOFF_LIM)
//   tec_dec1       successful transmit,   TEC -= 1 (floor 0, frozen at BOFF_LIM)
//   rec_inc1       receive error,         REC += 1 (saturates at 255)
//   rec_inc8       receive error (dominant-flag case), REC += 8
//   rec_dec1       successful reception (REC -= 1, or reload to REC_RESUME)
//   sample         one-cycle strobe at each bit sample point
//   rxbit          sampled bus value, 1 = recessive, valid with sample
//   tec/rec/erb    counter values
//   *_lt96/_ge96/_ge128/_ge256, erb_eq128   threshold flags (from registers)
//   erb_state      debug view of the ERB FSM (0 = IDLE, 1 = COUNT)
//
// All event inputs are level-sampled: a pulse held N cycles counts N times.
// ----------------------------------------------------------------------------
module fault_counters #(
    parameter int unsigned WARN_LIM   = 96,
    parameter int unsigned PASS_LIM   = 128,
    parameter int unsigned BOFF_LIM   = 256,
    parameter int unsigned ERB_LIM    = 128,
    parameter int unsigned REC_RESUME = 119
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       resetcount,
    input  logic       busoff,
    input  logic       tec_inc8,
    input  logic       tec_dec1,
    input  logic       rec_inc1,
    input  logic       rec_inc8,
    input  logic       rec_dec1,
    input  logic       sample,
    input  logic       rxbit,
    output logic [8:0] tec,
    output logic [7:0] rec,
    output logic [7:0] erb,
    output logic       rec_lt96,
    output logic       rec_ge96,
    output logic       rec_ge128,
    output logic       tec_lt96,
    output logic       tec_ge96,
    output logic       tec_ge128,
    output logic       tec_ge256,
    output logic       erb_eq128,
    output logic       erb_state
);

    // Length of one recovery sequence: 11 consecutive recessive bits.
    localparam int unsigned RUN_LEN = 11;

    typedef enum logic {
        ERB_IDLE  = 1'b0,
        ERB_COUNT = 1'b1
    } erb_state_t;

    erb_state_t state_q, state_d;
    logic [3:0] run_q, run_d;
    logic [8:0] tec_d;
    logic [7:0] rec_d;
    logic [7:0] erb_d;

    // ------------------------------------------------------------------
    // TEC next value. The sum is one bit wider than the counter so the
    // saturation compare sees the true result.
    // ------------------------------------------------------------------
    logic [9:0] tec_sum8;
    assign tec_sum8 = {1'b0, tec} + 10'd8;

    always_comb begin
        tec_d = tec;
        if (tec_inc8) begin
            tec_d = (tec_sum8 >= 10'(BOFF_LIM)) ? 9'(BOFF_LIM) : tec_sum8[8:0];
        end else if (tec_dec1 && (tec != 9'(BOFF_LIM)) && (tec != 9'd0)) begin
            // Bus-off value is sticky: only resetcount/reset leave it.
            tec_d = tec - 9'd1;
        end
    end

    // ------------------------------------------------------------------
    // REC next value. Increments saturate at 255; a successful reception
    // while error-passive reloads REC_RESUME instead of decrementing.
    // ------------------------------------------------------------------
    logic [8:0] rec_sum8, rec_sum1;
    assign rec_sum8 = {1'b0, rec} + 9'd8;
    assign rec_sum1 = {1'b0, rec} + 9'd1;

    always_comb begin
        rec_d = rec;
        if (rec_inc8) begin
            rec_d = rec_sum8[8] ? 8'hFF : rec_sum8[7:0];
        end else if (rec_inc1) begin
            rec_d = rec_sum1[8] ? 8'hFF : rec_sum1[7:0];
        end else if (rec_dec1) begin
            if (rec >= 8'(PASS_LIM)) begin
                rec_d = 8'(REC_RESUME);
            end else if (rec != 8'd0) begin
                rec_d = rec - 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // ERB FSM: state register / next-state / outputs (run + erb next).
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ERB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ERB_IDLE:  if (busoff)  state_d = ERB_COUNT;
            ERB_COUNT: if (!busoff) state_d = ERB_IDLE;
            default:   state_d = ERB_IDLE;
        endcase
    end

    always_comb begin
        run_d = run_q;
        erb_d = erb;
        if ((state_q == ERB_IDLE) || !busoff) begin
            // Leaving bus-off (or not yet counting) discards progress on
            // the same edge the FSM drops back to IDLE.
            run_d = 4'd0;
            erb_d = 8'd0;
        end else if (sample) begin
            if (!rxbit) begin
                run_d = 4'd0;
            end else if (run_q == 4'(RUN_LEN - 1)) begin
                // 11th recessive bit: close the sequence and count it.
                run_d = 4'd0;
                if (erb != 8'(ERB_LIM)) begin
                    erb_d = erb + 8'd1;
                end
            end else begin
                run_d = run_q + 4'd1;
            end
        end
    end

    assign erb_state = state_q;

    // ------------------------------------------------------------------
    // Counter registers. resetcount overrides every event but leaves the
    // ERB FSM state alone.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tec   <= 9'd0;
            rec   <= 8'd0;
            erb   <= 8'd0;
            run_q <= 4'd0;
        end else if (!resetcount) begin
            tec   <= 9'd0;
            rec   <= 8'd0;
            erb   <= 8'd0;
            run_q <= 4'd0;
        end else begin
            tec   <= tec_d;
            rec   <= rec_d;
            erb   <= erb_d;
            run_q <= run_d;
        end
    end

    // Threshold flags: decoded from registers only.
    assign tec_lt96  = (tec <  9'(WARN_LIM));
    assign tec_ge96  = (tec >= 9'(WARN_LIM));
    assign tec_ge128 = (tec >= 9'(PASS_LIM));
    assign tec_ge256 = (tec >= 9'(BOFF_LIM));
    assign rec_lt96  = (rec <  8'(WARN_LIM));
    assign rec_ge96  = (rec >= 8'(WARN_LIM));
    assign rec_ge128 = (rec >= 8'(PASS_LIM));
    assign erb_eq128 = (erb == 8'(ERB_LIM));

endmodule

// File: tb/tb_fault_counters.sv
module tb_fault_counters;

    localparam int W = 33;

    // Stimulus word: {busoff, resetcount, tec_inc8, tec_dec1, rec_inc1,
    //                 rec_inc8, rec_dec1, sample, rxbit}
    localparam logic [8:0] S_IDLE = 9'h080;
    localparam logic [8:0] S_TI8  = 9'h0C0;
    localparam logic [8:0] S_TD1  = 9'h0A0;
    localparam logic [8:0] S_RI1  = 9'h090;
    localparam logic [8:0] S_RI8  = 9'h088;
    localparam logic [8:0] S_RD1  = 9'h084;
    localparam logic [8:0] S_CLR  = 9'h000;
    localparam logic [8:0] S_REC1 = 9'h083; // sample, recessive
    localparam logic [8:0] S_DOM  = 9'h082; // sample, dominant
    localparam logic [8:0] S_NOSM = 9'h081; // rxbit=1 but no sample strobe
    localparam logic [8:0] B      = 9'h100; // busoff bit

    logic       clock = 1'b0;
    logic       reset;
    logic       resetcount, busoff;
    logic       tec_inc8, tec_dec1, rec_inc1, rec_inc8, rec_dec1;
    logic       sample, rxbit;
    logic [8:0] tec;
    logic [7:0] rec, erb;
    logic       rec_lt96, rec_ge96, rec_ge128;
    logic       tec_lt96, tec_ge96, tec_ge128, tec_ge256;
    logic       erb_eq128, erb_state;

    logic [W-1:0] exp_q[$];
    logic [8:0]   stim_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    fault_counters dut (
        .clock      (clock),
        .reset      (reset),
        .resetcount (resetcount),
        .busoff     (busoff),
        .tec_inc8   (tec_inc8),
        .tec_dec1   (tec_dec1),
        .rec_inc1   (rec_inc1),
        .rec_inc8   (rec_inc8),
        .rec_dec1   (rec_dec1),
        .sample     (sample),
        .rxbit      (rxbit),
        .tec        (tec),
        .rec        (rec),
        .erb        (erb),
        .rec_lt96   (rec_lt96),
        .rec_ge96   (rec_ge96),
        .rec_ge128  (rec_ge128),
        .tec_lt96   (tec_lt96),
        .tec_ge96   (tec_ge96),
        .tec_ge128  (tec_ge128),
        .tec_ge256  (tec_ge256),
        .erb_eq128  (erb_eq128),
        .erb_state  (erb_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- expected / observed packing ----------------
    function automatic logic [W-1:0] exp_vec(input int t, input int r, input int e);
        logic [8:0] tv;
        logic [7:0] rv, ev;
        tv = 9'(t);
        rv = 8'(r);
        ev = 8'(e);
        return {tv, rv, ev,
                (t < 96), (t >= 96), (t >= 128), (t >= 256),
                (r < 96), (r >= 96), (r >= 128), (e == 128)};
    endfunction

    function automatic logic [W-1:0] obs_vec();
        return {tec, rec, erb, tec_lt96, tec_ge96, tec_ge128, tec_ge256,
                rec_lt96, rec_ge96, rec_ge128, erb_eq128};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [8:0] s);
        @(negedge clock);
        {busoff, resetcount, tec_inc8, tec_dec1, rec_inc1, rec_inc8,
         rec_dec1, sample, rxbit} = s;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [8:0] s, input int t, input int r, input int e);
        stim_q.push_back(s);
        exp_q.push_back(exp_vec(t, r, e));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] ev;
        reset = 1'b0;
        {busoff, resetcount, tec_inc8, tec_dec1, rec_inc1, rec_inc8,
         rec_dec1, sample, rxbit} = S_IDLE;
        repeat (3) @(posedge clock);
        #1;
        exp_q.push_back(exp_vec(0, 0, 0));
        ev = exp_q.pop_front();
        n_checks++;
        if (obs_vec() !== ev) begin
            n_errors++;
            $display("FAIL reset_held: got %h expected %h", obs_vec(), ev);
        end
        @(negedge clock);
        reset = 1'b1;
        push(S_IDLE, 0, 0, 0);
        push(S_IDLE, 0, 0, 0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            ev = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== ev) begin
                n_errors++;
                $display("FAIL reset_release: got %h expected %h", obs_vec(), ev);
            end
        end
    endtask

    task automatic test_tec_thresholds();
        logic [W-1:0] ev;
        int k = 0;
        for (int i = 1; i <= 16; i++) push(S_TI8, 8 * i, 0, 0);
        push(S_TD1, 127, 0, 0);
        push(S_CLR, 0, 0, 0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            ev = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== ev) begin
                n_errors++;
                $display("FAIL tec_thresholds step %0d: got %h expected %h", k, obs_vec(), ev);
            end
            k++;
        end
    endtask

    task automatic test_tec_saturate();
        logic [W-1:0] ev;
        int k = 0;
        for (int i = 1; i <= 31; i++) push(S_TI8, 8 * i, 0, 0);
        for (int i = 1; i <= 4; i++) push(S_TD1, 248 - i, 0, 0);
        push(S_TI8, 252, 0, 0);
        push(S_TI8, 256, 0, 0);
        for (int i = 0; i < 3; i++) push(S_TD1, 256, 0, 0);
        push(S_TI8, 256, 0, 0);
        push(S_CLR, 0, 0, 0);
        push(S_TD1, 0, 0, 0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            ev = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== ev) begin
                n_errors++;
                $display("FAIL tec_saturate step %0d: got %h expected %h", k, obs_vec(), ev);
            end
            k++;
        end
    endtask

    task automatic test_rec();
        logic [W-1:0] ev;
        int k = 0;
        for (int i = 1; i <= 16; i++) push(S_RI8, 0, 8 * i, 0);
        push(S_RI1, 0, 129, 0);
        push(S_RI1, 0, 130, 0);
        push(S_RD1, 0, 119, 0);
        push(S_RD1, 0, 118, 0);
        push(S_CLR, 0, 0, 0);
        push(S_RD1, 0, 0, 0);
        for (int i = 1; i <= 31; i++) push(S_RI8, 0, 8 * i, 0);
        push(S_RI1, 0, 249, 0);
        push(S_RI1, 0, 250, 0);
        push(S_RI8, 0, 255, 0);
        push(S_RI1, 0, 255, 0);
        push(S_RD1, 0, 119, 0);
        push(S_CLR, 0, 0, 0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            ev = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== ev) begin
                n_errors++;
                $display("FAIL rec step %0d: got %h expected %h", k, obs_vec(), ev);
            end
            k++;
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] ev;
        int k = 0;
        push(S_TI8, 8, 0, 0);
        push(S_TI8, 16, 0, 0);
        for (int i = 1; i <= 6; i++) push(S_TD1, 16 - i, 0, 0);
        push(S_TI8 | S_TD1, 18, 0, 0);
        push(S_RI8 | S_RI1, 18, 8, 0);
        push(S_RI8 | S_RI1 | S_RD1, 18, 16, 0);
        push(S_RI1 | S_RD1, 18, 17, 0);
        push(S_TI8 | S_RI1, 26, 18, 0);
        push(S_TD1 | S_RD1, 25, 17, 0);
        push(9'h0FC, 33, 25, 0);
        push(S_CLR | 9'h07C, 0, 0, 0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            ev = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== ev) begin
                n_errors++;
                $display("FAIL simultaneous step %0d: got %h expected %h", k, obs_vec(), ev);
            end
            k++;
        end
    endtask

    task automatic test_erb();
        logic [W-1:0] ev;
        int k = 0;
        // Entering bus-off: first edge only moves IDLE -> COUNT.
        push(S_IDLE | B, 0, 0, 0);
        // Dominant bit after 10 recessive bits restarts the run.
        for (int i = 0; i < 10; i++) push(S_REC1 | B, 0, 0, 0);
        push(S_DOM | B, 0, 0, 0);
        // 128 full sequences; a non-strobed cycle inside each is ignored.
        for (int i = 1; i <= 128; i++) begin
            for (int j = 1; j <= 11; j++) begin
                push(S_REC1 | B, 0, 0, (j == 11) ? i : i - 1);
                if (j == 5) push(S_NOSM | B, 0, 0, i - 1);
            end
        end
        // Saturated: another full sequence is ignored.
        for (int j = 1; j <= 11; j++) push(S_REC1 | B, 0, 0, 128);
        // resetcount clears erb but the FSM keeps counting.
        push(S_CLR | B, 0, 0, 0);
        for (int j = 1; j <= 11; j++) push(S_REC1 | B, 0, 0, (j == 11) ? 1 : 0);
        for (int j = 1; j <= 5; j++) push(S_REC1 | B, 0, 0, 1);
        // busoff falls: erb cleared on that edge, no counting in IDLE.
        push(S_REC1, 0, 0, 0);
        for (int j = 1; j <= 11; j++) push(S_REC1, 0, 0, 0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            ev = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== ev) begin
                n_errors++;
                $display("FAIL erb step %0d: got %h expected %h", k, obs_vec(), ev);
            end
            if (k == 0 || k == 1435) begin
                n_checks++;
                if (erb_state !== 1'b1) begin
                    n_errors++;
                    $display("FAIL erb_state_count step %0d: got %b expected 1", k, erb_state);
                end
            end
            k++;
        end
        n_checks++;
        if (erb_state !== 1'b0) begin
            n_errors++;
            $display("FAIL erb_state_idle: got %b expected 0", erb_state);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] ev;
        push(S_TI8 | S_RI8, 8, 8, 0);
        push(S_TI8 | S_RI1, 16, 9, 0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            ev = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== ev) begin
                n_errors++;
                $display("FAIL reset_mid_setup: got %h expected %h", obs_vec(), ev);
            end
        end
        // Async assertion away from any edge: outputs clear immediately.
        @(negedge clock);
        {busoff, resetcount, tec_inc8, tec_dec1, rec_inc1, rec_inc8,
         rec_dec1, sample, rxbit} = S_IDLE;
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back(exp_vec(0, 0, 0));
        ev = exp_q.pop_front();
        n_checks++;
        if (obs_vec() !== ev) begin
            n_errors++;
            $display("FAIL reset_mid_async: got %h expected %h", obs_vec(), ev);
        end
        @(negedge clock);
        reset = 1'b1;
        push(S_TI8, 8, 0, 0);
        push(S_RI1, 8, 1, 0);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            ev = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== ev) begin
                n_errors++;
                $display("FAIL reset_mid_restart: got %h expected %h", obs_vec(), ev);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_tec_thresholds();
        test_tec_saturate();
        test_rec();
        test_simultaneous();
        test_erb();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
